// File: rtl/ram_prog_pkg.sv
// Shared definitions for the RAM program sender: loader sync sequence,
// field widths, FSM encoding and byte-selection helpers.
package ram_prog_pkg;

    localparam int PROG_SEQ_LENGTH = 9;
    localparam logic [8*PROG_SEQ_LENGTH-1:0] PROGRAM_SEQUENCE = "TEKNOFEST";

    localparam int LEN_W  = 32;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_LENGTH = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Header character idx, first character first.
    function automatic logic [7:0] header_byte(input logic [3:0] idx);
        logic [8*PROG_SEQ_LENGTH-1:0] seq;
        if (idx < 4'(PROG_SEQ_LENGTH)) begin
            seq = PROGRAM_SEQUENCE >> (8 * (PROG_SEQ_LENGTH - 1 - int'(idx)));
        end else begin
            seq = '0;
        end
        return seq[7:0];
    endfunction

    // Byte idx of a word, MSB first.
    function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            2'd3:    b = w[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ram_prog_sender_uart_tx.sv
// 8N1 serializer, LSB first, DIV cycles per bit. last_o marks the final
// cycle of the stop bit; the next cycle the serializer is idle again.
module uart_tx_byte #(
    parameter int DIV = 6250
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       last_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [9:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end_s;

    assign bit_end_s = busy_q && (cnt_q == CNT_MAX);
    assign ready_o   = ~busy_q;
    assign tx_o      = tx_q;
    assign last_o    = bit_end_s && (bit_q == 4'd9);

    // Bit timing and shift-out of {stop, data, start}.
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (!busy_q) begin
            if (valid_i) begin
                busy_d  = 1'b1;
                cnt_d   = '0;
                bit_d   = 4'd0;
                shift_d = {1'b1, data_i, 1'b0};
                tx_d    = 1'b0;
            end else begin
                tx_d    = 1'b1;
            end
        end else if (bit_end_s) begin
            cnt_d = '0;
            if (bit_q == 4'd9) begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
            end else begin
                bit_d   = bit_q + 4'd1;
                shift_d = {1'b1, shift_q[9:1]};
                tx_d    = shift_q[1];
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State register with synchronous reset to an idle-high line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            shift_q <= 10'h3FF;
            tx_q    <= 1'b1;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/ram_prog_sender.sv
// Streams "TEKNOFEST", a 32-bit word count and then the words (MSB first)
// from a synchronous-read memory over UART, in the RAM loader's format.
module ram_prog_sender
    import ram_prog_pkg::*;
#(
    parameter int CPU_CLK    = 60_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [31:0]           word_count_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [31:0]           rd_data_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int DIV = CPU_CLK / BAUD_RATE;

    state_e                state_q, state_d;
    logic [3:0]            byte_idx_q, byte_idx_d;
    logic [LEN_W-1:0]      count_q, count_d;
    logic [LEN_W-1:0]      word_idx_q, word_idx_d;
    logic [LEN_W-1:0]      fetch_idx_q, fetch_idx_d;
    logic [WORD_W-1:0]     hold_q, hold_d;
    logic [WORD_W-1:0]     out_q, out_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  cap_q;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  ser_valid_s, ser_ready_s, ser_last_s, accept_s;
    logic [7:0]            ser_data_s;

    uart_tx_byte #(.DIV(DIV)) u_tx (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (ser_data_s),
        .valid_i (ser_valid_s),
        .ready_o (ser_ready_s),
        .tx_o    (tx_o),
        .last_o  (ser_last_s)
    );

    assign accept_s  = ser_valid_s && ser_ready_s;
    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = rd_addr_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

    // Byte mux: byte 0 of a word comes straight from the holding register,
    // bytes 1..3 from out_q so the next prefetch may overwrite hold_q.
    always_comb begin
        ser_valid_s = 1'b0;
        ser_data_s  = 8'h00;
        case (state_q)
            ST_HEADER: begin
                ser_valid_s = 1'b1;
                ser_data_s  = header_byte(byte_idx_q);
            end
            ST_LENGTH: begin
                ser_valid_s = 1'b1;
                ser_data_s  = word_byte(count_q, byte_idx_q[1:0]);
            end
            ST_DATA: begin
                ser_valid_s = 1'b1;
                if (byte_idx_q == 4'd0) begin
                    ser_data_s = hold_q[31:24];
                end else begin
                    ser_data_s = word_byte(out_q, byte_idx_q[1:0]);
                end
            end
            default: begin
                ser_valid_s = 1'b0;
                ser_data_s  = 8'h00;
            end
        endcase
    end

    // Next-state, counters and prefetch.
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        count_d     = count_q;
        word_idx_d  = word_idx_q;
        fetch_idx_d = fetch_idx_q;
        out_d       = out_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        hold_d      = cap_q ? rd_data_i : hold_q;

        case (state_q)
            ST_IDLE: begin
                // done_q guard: a new start is taken only after the done cycle.
                if (start_i && !done_q) begin
                    state_d     = ST_HEADER;
                    byte_idx_d  = 4'd0;
                    count_d     = word_count_i;
                    word_idx_d  = 32'd0;
                    fetch_idx_d = 32'd0;
                    rd_addr_d   = '0;
                    busy_d      = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (accept_s) begin
                    if (byte_idx_q == 4'(PROG_SEQ_LENGTH - 1)) begin
                        byte_idx_d = 4'd0;
                        state_d    = ST_LENGTH;
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end else begin
                    state_d = ST_HEADER;
                end
            end
            ST_LENGTH: begin
                if (accept_s) begin
                    if ((byte_idx_q == 4'd0) && (fetch_idx_q < count_q)) begin
                        rd_en_d     = 1'b1;
                        rd_addr_d   = fetch_idx_q[ADDR_WIDTH-1:0];
                        fetch_idx_d = fetch_idx_q + 32'd1;
                    end else begin
                        rd_en_d = 1'b0;
                    end
                    if (byte_idx_q == 4'd3) begin
                        byte_idx_d = 4'd0;
                        state_d    = (count_q == 32'd0) ? ST_DONE : ST_DATA;
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end else begin
                    state_d = ST_LENGTH;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    if (byte_idx_q == 4'd0) begin
                        out_d      = hold_q;
                        word_idx_d = word_idx_q + 32'd1;
                        if (fetch_idx_q < count_q) begin
                            rd_en_d     = 1'b1;
                            rd_addr_d   = fetch_idx_q[ADDR_WIDTH-1:0];
                            fetch_idx_d = fetch_idx_q + 32'd1;
                        end else begin
                            rd_en_d = 1'b0;
                        end
                    end else begin
                        out_d = out_q;
                    end
                    if (byte_idx_q == 4'd3) begin
                        byte_idx_d = 4'd0;
                        state_d    = (word_idx_q == count_q) ? ST_DONE : ST_DATA;
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DONE: begin
                if (ser_last_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            byte_idx_q  <= 4'd0;
            count_q     <= 32'd0;
            word_idx_q  <= 32'd0;
            fetch_idx_q <= 32'd0;
            hold_q      <= 32'd0;
            out_q       <= 32'd0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            cap_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            fetch_idx_q <= fetch_idx_d;
            hold_q      <= hold_d;
            out_q       <= out_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            cap_q       <= rd_en_q;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_ram_prog_sender.sv
// Scoreboard bench: expected bytes, read addresses and frame timing are
// queued at start and checked by a UART receiver and read-port monitor.
module tb_ram_prog_sender;

    localparam int DIV   = 16;
    localparam int AW    = 2;
    localparam int FRAME = 10 * DIV + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   wc;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic          tx;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    ram_prog_sender #(.CPU_CLK(16), .BAUD_RATE(1), .ADDR_WIDTH(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .word_count_i (wc),
        .rd_en_o      (rd_en),
        .rd_addr_o    (rd_addr),
        .rd_data_i    (rd_data),
        .tx_o         (tx),
        .busy_o       (busy),
        .done_o       (done)
    );

    logic [31:0] mem [4];
    initial begin
        mem[0] = 32'h0000_0013;
        mem[1] = 32'hDEAD_BEEF;
        mem[2] = 32'h1122_3344;
        mem[3] = 32'hA5A5_5A5A;
    end

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    logic [7:0] exp_bytes [$];
    int         exp_addr  [$];
    int         exp_first [$];
    int         exp_nfr   [$];
    int         exp_done_cyc = -1;
    bit         mon_en = 1'b1;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
        end
    endtask

    task automatic push_xfer(input int first, input int n);
        string hdr;
        logic [31:0] w;
        hdr = "TEKNOFEST";
        for (int i = 0; i < 9; i++) exp_bytes.push_back(hdr[i]);
        w = n;
        for (int i = 3; i >= 0; i--) exp_bytes.push_back(w[8*i +: 8]);
        for (int k = 0; k < n; k++) begin
            w = mem[k % 4];
            exp_addr.push_back(k % 4);
            for (int i = 3; i >= 0; i--) exp_bytes.push_back(w[8*i +: 8]);
        end
        exp_first.push_back(first);
        exp_nfr.push_back(13 + 4 * n);
    endtask

    // Called at a negedge; start is sampled at the next posedge.
    task automatic start_xfer(input int n);
        wc    = n;
        start = 1'b1;
        push_xfer(cyc + 2, n);
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_rise", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (done !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check_eq("done_seen", done, 1);
    endtask

    // UART receiver: samples mid-bit, checks byte, stop bit and frame start times.
    initial begin : rx_mon
        int         s;
        int         prev_s;
        int         left;
        logic [7:0] b;
        logic       stopb;
        left   = 0;
        prev_s = 0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                s = cyc;
                repeat (DIV + DIV / 2) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    b[j] = tx;
                    repeat (DIV) @(negedge clk);
                end
                stopb = tx;
                repeat (DIV / 2 - 1) @(negedge clk);
                if (mon_en) begin
                    if (left == 0) begin
                        check_eq("frame_expected", exp_first.size() > 0, 1);
                        if (exp_first.size() > 0) begin
                            check_eq("first_start_cyc", s, exp_first.pop_front());
                            left = exp_nfr.pop_front();
                        end
                    end else begin
                        check_eq("frame_spacing", s - prev_s, FRAME);
                    end
                    check_eq("byte_expected", exp_bytes.size() > 0, 1);
                    if (exp_bytes.size() > 0) check_eq("byte", b, exp_bytes.pop_front());
                    check_eq("stop_bit", stopb, 1);
                    if (left > 0) left--;
                    if (left == 0) exp_done_cyc = s + 10 * DIV;
                end
                prev_s = s;
            end
        end
    end

    // Done pulse timing and busy low in the done cycle.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            check_eq("done_cyc", cyc, exp_done_cyc);
            check_eq("busy_in_done", busy, 0);
            exp_done_cyc = -1;
        end
    end

    // Read-port monitor: addresses in order.
    always @(negedge clk) begin
        if (rd_en === 1'b1 && mon_en) begin
            check_eq("rd_expected", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0) check_eq("rd_addr", rd_addr, exp_addr.pop_front());
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

    initial begin : main
        int d;
        int saved_done;
        int tx_low;
        rst   = 1'b1;
        start = 1'b0;
        wc    = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rd_en", rd_en, 0);
        check_eq("rst_rd_addr", rd_addr, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Count 0, two words, wrap over a 4-word memory.
        start_xfer(0);
        wait_done(13 * FRAME + 100);
        @(negedge clk);
        start_xfer(2);
        wait_done(21 * FRAME + 100);
        @(negedge clk);
        start_xfer(5);
        wait_done(33 * FRAME + 100);
        @(negedge clk);

        // start_i held high: one transfer, then a second after done.
        wc    = 32'd1;
        start = 1'b1;
        push_xfer(cyc + 2, 1);
        @(negedge clk);
        check_eq("busy_rise_held", busy, 1);
        wait_done(17 * FRAME + 100);
        d = cyc;
        push_xfer(d + 3, 1);
        @(negedge clk);
        check_eq("busy_low_after_done", busy, 0);
        @(negedge clk);
        check_eq("busy_restart", busy, 1);
        start = 1'b0;
        wait_done(17 * FRAME + 100);
        @(negedge clk);

        // Reset in the middle of data byte 2.
        mon_en     = 1'b0;
        saved_done = n_done;
        wc         = 32'd2;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15 * FRAME + 50) @(negedge clk);
        check_eq("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("tx_after_rst", tx, 1);
        check_eq("busy_after_rst", busy, 0);
        check_eq("rd_addr_after_rst", rd_addr, 0);
        tx_low = 0;
        repeat (400) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
        end
        check_eq("tx_idle_after_rst", tx_low, 0);
        check_eq("no_done_after_rst", n_done, saved_done);
        mon_en = 1'b1;

        // Recovery after abort.
        start_xfer(3);
        wait_done(25 * FRAME + 100);
        repeat (5) @(negedge clk);

        check_eq("bytes_left", exp_bytes.size(), 0);
        check_eq("addrs_left", exp_addr.size(), 0);
        check_eq("xfers_left", exp_first.size(), 0);
        check_eq("done_count", n_done, 6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
